capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Sequences the ADC capture datapath: arm, trigger qualification, trigger-offset delay, and multi-segment timing.
- Issues capture_go/segment_go toward the sample FIFO and consumes its per-segment completion pulses.
- Sits between the register block (configuration) and the FIFO (data path), entirely in the ADC sample-clock domain.

Parameters:
- pSEG_WIDTH, 16, width of segment count and num_segments.
- pCYC_WIDTH, 20, width of segment_cycles.
- pOFS_WIDTH, 32, width of trigger_offset and trigger_length.

Ports:
- adc_clk  in  1  ADC sample clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- arm_i  in  1  level; a rising edge arms the sequencer.
- trigger_i  in  1  qualified trigger, active high.
- trigger_wait_i  in  1  1 = require trigger_i low before accepting a trigger.
- trigger_offset_i  in  pOFS_WIDTH  cycles from trigger to segment start.
- num_segments_i  in  pSEG_WIDTH  segments per capture; 0 is treated as 1.
- segment_cycles_i  in  pCYC_WIDTH  0 = every segment is trigger-started; else the spacing between segment starts.
- segment_done_i  in  1  1-cycle pulse from the FIFO: current segment is full.
- abort_i  in  1  1-cycle pulse; kills the current operation.
- armed_o  out  1  high in WAIT_INACTIVE and ARMED.
- capture_go_o  out  1  high from the first segment_go until completion.
- segment_go_o  out  1  1-cycle pulse at each segment start.
- seg_count_o  out  pSEG_WIDTH  number of completed segments.
- trigger_length_o  out  pOFS_WIDTH  cycles capture_go_o was high; saturates.
- timing_err_o  out  1  sticky; a segment overran its spacing.
- done_o  out  1  1-cycle pulse when the capture completes.
- state_o  out  3  current state encoding.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE.
  - Internal arm-edge register cleared.
- States and transitions:
  - IDLE(0): on an arm_i rising edge, clear seg_count_o, trigger_length_o and timing_err_o. Go to WAIT_INACTIVE if trigger_wait_i=1, else ARMED.
  - WAIT_INACTIVE(1): go to ARMED on the first cycle with trigger_i=0.
  - ARMED(2): trigger_i=1 loads the offset counter with trigger_offset_i and goes to OFFSET.
  - OFFSET(3): decrement each cycle. When the counter reads 0, pulse segment_go_o (registered), set capture_go_o and go to CAPTURE.
    - Latency: trigger sampled at cycle N gives segment_go_o at cycle N+1+offset. offset=0 gives N+1.
  - CAPTURE(4): on segment_done_i, seg_count_o increments.
    - If the incremented count equals max(num_segments_i,1), go to DONE.
    - Else if segment_cycles_i=0, go to ARMED. trigger_wait_i is not re-applied and the offset is applied per segment.
    - Else go to GAP.
  - GAP(5): the spacing counter was loaded with segment_cycles_i-1 at the previous segment_go. The next segment_go_o fires when the counter reaches 0 and returns to CAPTURE, so starts are exactly segment_cycles_i cycles apart.
  - DONE(6): for one cycle, drop capture_go_o, pulse done_o, then go to IDLE. A new capture needs a fresh arm_i rising edge.
- Gap overrun:
  - If segment_done_i arrives after the spacing counter has already expired, set timing_err_o.
  - segment_go_o then fires the cycle after segment_done_i.
  - This also covers segment_cycles_i=1.
- Spacing counter runs independently of state from each segment_go; it stops at 0 and does not wrap.
- trigger_length_o increments every cycle capture_go_o=1 and holds at all-ones.
- arm_i low in WAIT_INACTIVE or ARMED returns to IDLE; arm_i is ignored in OFFSET, CAPTURE and GAP.
- abort_i in any state:
  - IDLE next cycle.
  - capture_go_o and armed_o cleared.
  - No done_o pulse.
  - seg_count_o, trigger_length_o and timing_err_o hold.
- segment_done_i outside CAPTURE/GAP is ignored.
- Config inputs are sampled when used (arm, trigger, segment completion); software must hold them stable while armed.
- reset_n assertion mid-capture clears everything asynchronously; outputs are 0 in the same cycle.

Optional Feature:
- Macro: CAPTURE_SEQ_TIMEOUT_EN.
- When defined:
  - Adds input timeout_cycles_i (24 bits) and output timeout_o (sticky, cleared on arm).
  - In ARMED, a counter counts cycles without a trigger. When it reaches timeout_cycles_i (non-zero), set timeout_o and go to IDLE with no done_o.
  - timeout_cycles_i=0 disables the timeout.
- When not defined: both ports are absent and ARMED waits indefinitely.

Test Plan:
- Single segment: num_segments=1, offset=0, trigger at cycle N.
  - Response: segment_go_o at N+1, capture_go_o high until segment_done_i, done_o one cycle later, seg_count_o=1.
- Offset: offset=5, trigger at N.
  - Response: segment_go_o at N+6, trigger_length_o equals the cycles from N+6 to segment_done.
- Timed segments: num_segments=4, segment_cycles=100, segment_done arrives 60 cycles after each start.
  - Response: segment_go_o at S, S+100, S+200, S+300; done_o after the 4th done; timing_err_o=0.
- Overrun and trigger_wait:
  - segment_cycles=50, segment_done at 70 → timing_err_o=1; next segment_go_o the cycle after done.
  - trigger_wait=1 with trigger_i held high at arm → stays in WAIT_INACTIVE until trigger_i falls.
- Abort/reset:
  - abort_i in GAP after 2 segments → IDLE, seg_count_o=2, no done_o.
  - reset_n low mid-CAPTURE → all outputs 0 immediately.
- Timeout (CAPTURE_SEQ_TIMEOUT_EN): timeout=1000, no trigger.
  - Response: timeout_o=1 and state_o=0 after 1000 cycles in ARMED.

Source files
------------

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: segment handshake between the capture sequencer (master) and the sample FIFO (slave)
interface capture_sequencer_if;
    logic capture_go_o;
    logic segment_go_o;
    logic segment_done_i;
    modport master (output capture_go_o, segment_go_o, input segment_done_i);
    modport slave (input capture_go_o, segment_go_o, output segment_done_i);
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer: arm, trigger qualification, trigger offset and multi-segment timing for ADC capture
// Optional trigger timeout in ARMED is enabled by defining CAPTURE_SEQ_TIMEOUT_EN.
module capture_sequencer #(
    parameter int pSEG_WIDTH = 16,
    parameter int pCYC_WIDTH = 20,
    parameter int pOFS_WIDTH = 32
) (
    input  logic                  adc_clk,
    input  logic                  reset_n,
    input  logic                  arm_i,
    input  logic                  trigger_i,
    input  logic                  trigger_wait_i,
    input  logic [pOFS_WIDTH-1:0] trigger_offset_i,
    input  logic [pSEG_WIDTH-1:0] num_segments_i,
    input  logic [pCYC_WIDTH-1:0] segment_cycles_i,
    input  logic                  abort_i,
    capture_sequencer_if.master   fifo,
    output logic                  armed_o,
    output logic [pSEG_WIDTH-1:0] seg_count_o,
    output logic [pOFS_WIDTH-1:0] trigger_length_o,
    output logic                  timing_err_o,
    output logic                  done_o,
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    input  logic [23:0]           timeout_cycles_i,
    output logic                  timeout_o,
`endif
    output logic [2:0]            state_o
);
    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_INACTIVE = 3'd1,
        ARMED         = 3'd2,
        OFFSET        = 3'd3,
        CAPTURE       = 3'd4,
        GAP           = 3'd5,
        DONE          = 3'd6
    } state_t;

    state_t                state, state_nx;
    logic                  arm_q;
    logic [pOFS_WIDTH-1:0] ofs_cnt, ofs_cnt_nx;
    logic [pCYC_WIDTH-1:0] gap_cnt;
    logic [pSEG_WIDTH-1:0] seg_next, seg_target;
    logic                  arm_rise, seg_last, gap_expired;
    logic                  fire, seg_inc, clr_stats, timing_set;

    assign arm_rise    = arm_i & ~arm_q;
    assign seg_next    = seg_count_o + 1'b1;
    assign seg_target  = (num_segments_i == '0) ? pSEG_WIDTH'(1) : num_segments_i;
    assign seg_last    = seg_next == seg_target;
    assign gap_expired = gap_cnt == '0;
    assign armed_o     = (state == WAIT_INACTIVE) || (state == ARMED);
    assign done_o      = state == DONE;
    assign state_o     = state;

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic        tmo_hit, tmo_set;
    assign tmo_hit = (timeout_cycles_i != '0) && (tmo_cnt + 24'd1 == timeout_cycles_i);
`endif

    always_comb begin
        state_nx   = state;
        ofs_cnt_nx = ofs_cnt;
        fire       = 1'b0;
        seg_inc    = 1'b0;
        clr_stats  = 1'b0;
        timing_set = 1'b0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
        tmo_set    = 1'b0;
`endif
        if (abort_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (arm_rise) begin
                    clr_stats = 1'b1;
                    state_nx  = trigger_wait_i ? WAIT_INACTIVE : ARMED;
                end
                WAIT_INACTIVE: state_nx = !arm_i ? IDLE : (!trigger_i ? ARMED : WAIT_INACTIVE);
                ARMED: begin
                    if (!arm_i) begin
                        state_nx = IDLE;
                    end else if (trigger_i) begin
                        // Zero offset starts the segment straight from the trigger cycle.
                        fire       = trigger_offset_i == '0;
                        ofs_cnt_nx = trigger_offset_i - 1'b1;
                        state_nx   = fire ? CAPTURE : OFFSET;
                    end
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        tmo_set  = 1'b1;
                        state_nx = IDLE;
                    end
`endif
                end
                OFFSET: begin
                    fire       = ofs_cnt == '0;
                    ofs_cnt_nx = ofs_cnt - 1'b1;
                    state_nx   = fire ? CAPTURE : OFFSET;
                end
                CAPTURE: if (fifo.segment_done_i) begin
                    seg_inc = 1'b1;
                    if (seg_last) begin
                        state_nx = DONE;
                    end else if (segment_cycles_i == '0) begin
                        state_nx = ARMED;
                    end else if (gap_expired) begin
                        timing_set = 1'b1;
                        fire       = 1'b1;
                    end else begin
                        state_nx = GAP;
                    end
                end
                GAP: begin
                    fire     = gap_expired;
                    state_nx = gap_expired ? CAPTURE : GAP;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            arm_q             <= 1'b0;
            ofs_cnt           <= '0;
            gap_cnt           <= '0;
            fifo.segment_go_o <= 1'b0;
            fifo.capture_go_o <= 1'b0;
            seg_count_o       <= '0;
            trigger_length_o  <= '0;
            timing_err_o      <= 1'b0;
        end else begin
            state             <= state_nx;
            arm_q             <= arm_i;
            ofs_cnt           <= ofs_cnt_nx;
            fifo.segment_go_o <= fire;
            fifo.capture_go_o <= fire | (fifo.capture_go_o && state_nx != IDLE && state_nx != DONE);
            // Spacing counter restarts at every segment start and parks at zero.
            gap_cnt           <= fire ? ((segment_cycles_i == '0) ? '0 : segment_cycles_i - 1'b1)
                                      : (gap_expired ? gap_cnt : gap_cnt - 1'b1);
            seg_count_o       <= clr_stats ? '0 : (seg_inc ? seg_next : seg_count_o);
            trigger_length_o  <= clr_stats ? '0
                               : ((fifo.capture_go_o && !(&trigger_length_o)) ? trigger_length_o + 1'b1 : trigger_length_o);
            timing_err_o      <= !clr_stats && (timing_err_o || timing_set);
        end
    end

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt   <= '0;
            timeout_o <= 1'b0;
        end else begin
            tmo_cnt   <= (state == ARMED && state_nx == ARMED) ? tmo_cnt + 24'd1 : '0;
            timeout_o <= !clr_stats && (timeout_o || tmo_set);
        end
    end
`endif
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: table-driven captures with a segment_go/done scoreboard plus abort, wait and reset sequences
module tb_capture_sequencer;
    localparam int SW = 16, CW = 20, OW = 32;

    logic          adc_clk = 1'b0, reset_n = 1'b0;
    logic          arm_i = 1'b0, trigger_i = 1'b0, trigger_wait_i = 1'b0, abort_i = 1'b0;
    logic [OW-1:0] trigger_offset_i = '0;
    logic [SW-1:0] num_segments_i = '0;
    logic [CW-1:0] segment_cycles_i = '0;
    logic          armed_o, timing_err_o, done_o;
    logic [SW-1:0] seg_count_o;
    logic [OW-1:0] trigger_length_o;
    logic [2:0]    state_o;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    logic [23:0]   timeout_cycles_i = '0;
    logic          timeout_o;
`endif

    capture_sequencer_if fifo();

    capture_sequencer #(.pSEG_WIDTH(SW), .pCYC_WIDTH(CW), .pOFS_WIDTH(OW)) dut (
        .adc_clk(adc_clk), .reset_n(reset_n), .arm_i(arm_i), .trigger_i(trigger_i),
        .trigger_wait_i(trigger_wait_i), .trigger_offset_i(trigger_offset_i),
        .num_segments_i(num_segments_i), .segment_cycles_i(segment_cycles_i),
        .abort_i(abort_i), .fifo(fifo), .armed_o(armed_o), .seg_count_o(seg_count_o),
        .trigger_length_o(trigger_length_o), .timing_err_o(timing_err_o), .done_o(done_o),
`ifdef CAPTURE_SEQ_TIMEOUT_EN
        .timeout_cycles_i(timeout_cycles_i), .timeout_o(timeout_o),
`endif
        .state_o(state_o)
    );

    always #5 adc_clk = ~adc_clk;

    int cnt = 0;
    always @(posedge adc_clk) cnt <= cnt + 1;

    int errors = 0, checks = 0;
    int exp_go[$], exp_done[$];

    typedef struct {
        int ofs;
        int nseg;
        int cyc;
        int dd;
        int exp_seg;
        bit exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge adc_clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cnt < t) step();
    endtask

    always @(negedge adc_clk) if (reset_n) begin
        if (fifo.segment_go_o) begin
            if (exp_go.size() == 0) chk("segment_go unexpected at cycle", cnt, -1);
            else chk("segment_go cycle", cnt, exp_go.pop_front());
        end
        if (done_o) begin
            if (exp_done.size() == 0) chk("done unexpected at cycle", cnt, -1);
            else chk("done cycle", cnt, exp_done.pop_front());
        end
    end

    task automatic arm_seq();
        arm_i = 1'b0;
        step();
        arm_i = 1'b1;
        step();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nseg_eff, t, go, prev, first;
        nseg_eff = (v.nseg == 0) ? 1 : v.nseg;
        trigger_offset_i = OW'(v.ofs);
        num_segments_i   = SW'(v.nseg);
        segment_cycles_i = CW'(v.cyc);
        trigger_wait_i   = 1'b0;
        arm_seq();
        trigger_i = 1'b1; t = cnt; step(); trigger_i = 1'b0;
        prev = 0; first = 0;
        for (int k = 0; k < nseg_eff; k++) begin
            if (k == 0 || v.cyc == 0) go = t + 1 + v.ofs;
            else go = (v.dd >= v.cyc) ? prev + v.dd + 1 : prev + v.cyc;
            if (k == 0) first = go;
            exp_go.push_back(go);
            prev = go;
            wait_until(go + v.dd);
            fifo.segment_done_i = 1'b1; step(); fifo.segment_done_i = 1'b0;
            if (k < nseg_eff - 1 && v.cyc == 0) begin
                trigger_i = 1'b1; t = cnt; step(); trigger_i = 1'b0;
            end
        end
        exp_done.push_back(prev + v.dd + 1);
        step();
        chk($sformatf("v%0d seg_count", idx), seg_count_o, v.exp_seg);
        chk($sformatf("v%0d trigger_length", idx), trigger_length_o, prev + v.dd - first + 1);
        chk($sformatf("v%0d timing_err", idx), timing_err_o, v.exp_err);
        chk($sformatf("v%0d state", idx), state_o, 0);
        chk($sformatf("v%0d capture_go", idx), fifo.capture_go_o, 0);
        chk($sformatf("v%0d pending events", idx), exp_go.size() + exp_done.size(), 0);
    endtask

    initial begin
        int t;
        //          ofs nseg cyc  dd seg err
        vecs[0] = '{0,  1,   0,   10, 1, 1'b0};
        vecs[1] = '{5,  1,   0,   20, 1, 1'b0};
        vecs[2] = '{0,  4,   100, 60, 4, 1'b0};
        vecs[3] = '{0,  3,   50,  70, 3, 1'b1};
        vecs[4] = '{2,  0,   0,   7,  1, 1'b0};
        vecs[5] = '{3,  2,   0,   5,  2, 1'b0};
        vecs[6] = '{1,  2,   1,   3,  2, 1'b1};
        fifo.segment_done_i = 1'b0;

        step(3);
        chk("reset state", state_o, 0);
        chk("reset capture_go", fifo.capture_go_o, 0);
        chk("reset segment_go", fifo.segment_go_o, 0);
        chk("reset armed", armed_o, 0);
        chk("reset outputs", {seg_count_o, trigger_length_o, timing_err_o, done_o}, 0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Trigger held high at arm with trigger_wait: must sit in WAIT_INACTIVE.
        trigger_wait_i = 1'b1;
        trigger_i = 1'b1;
        arm_seq();
        step(3);
        chk("wait_inactive state", state_o, 1);
        chk("wait_inactive armed", armed_o, 1);
        trigger_i = 1'b0;
        step();
        chk("wait released to armed", state_o, 2);
        arm_i = 1'b0;
        step();
        chk("arm low returns idle", state_o, 0);
        chk("arm low clears armed", armed_o, 0);
        trigger_wait_i = 1'b0;

        // Abort in GAP after two completed segments.
        trigger_offset_i = '0; num_segments_i = 4; segment_cycles_i = 100;
        arm_seq();
        trigger_i = 1'b1; t = cnt; step(); trigger_i = 1'b0;
        exp_go.push_back(t + 1);
        wait_until(t + 61); fifo.segment_done_i = 1'b1; step(); fifo.segment_done_i = 1'b0;
        exp_go.push_back(t + 101);
        wait_until(t + 161); fifo.segment_done_i = 1'b1; step(); fifo.segment_done_i = 1'b0;
        wait_until(t + 170);
        chk("gap state before abort", state_o, 5);
        abort_i = 1'b1; step(); abort_i = 1'b0;
        chk("abort state", state_o, 0);
        chk("abort seg_count", seg_count_o, 2);
        chk("abort capture_go", fifo.capture_go_o, 0);
        chk("abort armed", armed_o, 0);
        step(40);
        chk("abort length holds", trigger_length_o, 170);
        chk("abort pending events", exp_go.size() + exp_done.size(), 0);

`ifdef CAPTURE_SEQ_TIMEOUT_EN
        timeout_cycles_i = 24'd1000;
        arm_seq();
        step(999);
        chk("timeout not yet", state_o, 2);
        step();
        chk("timeout state", state_o, 0);
        chk("timeout flag", timeout_o, 1);
        timeout_cycles_i = '0;
`endif

        // Asynchronous reset in the middle of a capture.
        trigger_offset_i = '0; num_segments_i = 1; segment_cycles_i = '0;
        arm_seq();
        trigger_i = 1'b1; t = cnt; step(); trigger_i = 1'b0;
        exp_go.push_back(t + 1);
        wait_until(t + 6);
        chk("pre-reset capture_go", fifo.capture_go_o, 1);
        reset_n = 1'b0;
        #1;
        chk("async reset capture_go", fifo.capture_go_o, 0);
        chk("async reset state", state_o, 0);
        chk("async reset length", trigger_length_o, 0);
        chk("async reset segment_go", fifo.segment_go_o, 0);
        arm_i = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);
        chk("post-reset state", state_o, 0);
        chk("final pending events", exp_go.size() + exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
